// File: rtl/apb_reg_bridge.sv
// rtl/apb_reg_bridge.sv - APB3 slave to single-cycle register-request bridge
//
// Each APB transfer becomes exactly one reg_req pulse towards the register
// blocks. Read data is captured RD_LAT cycles after the pulse. Addresses at
// or above ADDR_LIMIT are answered with pslverr and never reach the registers.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   psel, penable, pwrite      APB control
//   paddr, pwdata              APB address / write data
//   prdata, pready, pslverr    APB response (registered)
//   reg_req                    one-cycle register access strobe
//   reg_wr, reg_addr, reg_wdata register command, qualified by reg_req
//   reg_rdata                  register read data, valid RD_LAT cycles after reg_req

module apb_reg_bridge #(
    parameter int REG_DW     = 8,
    parameter int REG_AW     = 8,
    parameter int RD_LAT     = 1,
    parameter int ADDR_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [REG_AW-1:0] paddr,
    input  logic [REG_DW-1:0] pwdata,
    output logic [REG_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              reg_req,
    output logic              reg_wr,
    output logic [REG_AW-1:0] reg_addr,
    output logic [REG_DW-1:0] reg_wdata,
    input  logic [REG_DW-1:0] reg_rdata
);

    // One extra bit so a limit equal to 2**REG_AW still compares correctly.
    localparam logic [REG_AW:0] LIMIT    = ADDR_LIMIT[REG_AW:0];
    localparam logic [2:0]      RD_LAT_C = RD_LAT[2:0];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              reg_req_q;
    logic              reg_wr_q;
    logic [REG_AW-1:0] reg_addr_q;
    logic [REG_DW-1:0] reg_wdata_q;
    logic [REG_DW-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;

    logic              in_range;

    assign in_range = ({1'b0, paddr} < LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reg_req_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            reg_req_q <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Only the setup phase starts a transfer; a penable held
                    // high after completion can never retrigger.
                    if (psel && !penable) begin
                        prdata_q <= '0;
                        if (in_range) begin
                            reg_wr_q    <= pwrite;
                            reg_addr_q  <= paddr;
                            reg_wdata_q <= pwdata;
                            reg_req_q   <= 1'b1;
                            state_q     <= REQ;
                        end else begin
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (reg_wr_q) begin
                        pready_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q   <= RD_LAT_C;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        prdata_q <= reg_rdata;
                        pready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    // psel is not consulted: an abandoned transfer still
                    // finishes here and the FSM cannot hang.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prdata    = prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign reg_req   = reg_req_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb/tb_apb_reg_bridge.sv - directed bench for apb_reg_bridge, RD_LAT 1 and 3

module tb_apb_reg_bridge;

    logic       clk;
    logic       rst_n;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;

    logic [7:0] prdata1, prdata3;
    logic       pready1, pready3;
    logic       pslverr1, pslverr3;
    logic       req1, req3;
    logic       wr1, wr3;
    logic [7:0] addr1, addr3;
    logic [7:0] wdata1, wdata3;
    logic [7:0] rdata1, rdata3;

    int n_assert = 0;
    int n_fail   = 0;

    apb_reg_bridge #(.REG_DW(8), .REG_AW(8), .RD_LAT(1), .ADDR_LIMIT(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
        .pslverr(pslverr1), .reg_req(req1), .reg_wr(wr1), .reg_addr(addr1),
        .reg_wdata(wdata1), .reg_rdata(rdata1)
    );

    apb_reg_bridge #(.REG_DW(8), .REG_AW(8), .RD_LAT(3), .ADDR_LIMIT(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3), .reg_req(req3), .reg_wr(wr3), .reg_addr(addr3),
        .reg_wdata(wdata3), .reg_rdata(rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register block models: data is driven only in the cycle exactly RD_LAT
    // after the read request, 0xEE (stale) at all other times.
    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [3:0] pipe1, pipe3;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[2] = 8'h5A;
        mem3[2] = 8'h5A;
        pipe1 = '0;
        pipe3 = '0;
    end

    always @(posedge clk) begin
        pipe1 <= {pipe1[2:0], req1 & ~wr1};
        pipe3 <= {pipe3[2:0], req3 & ~wr3};
        if (req1 && wr1) mem1[addr1[3:0]] <= wdata1;
        if (req3 && wr3) mem3[addr3[3:0]] <= wdata3;
    end

    assign rdata1 = pipe1[0] ? mem1[addr1[3:0]] : 8'hEE;
    assign rdata3 = pipe3[2] ? mem3[addr3[3:0]] : 8'hEE;

    // Request monitor.
    int rq1 = 0;
    int rq3 = 0;
    logic       cw1, cw3;
    logic [7:0] ca1, ca3, cd1, cd3;

    always @(negedge clk) begin
        if (req1) begin rq1++; cw1 = wr1; ca1 = addr1; cd1 = wdata1; end
        if (req3) begin rq3++; cw3 = wr3; ca3 = addr3; cd3 = wdata3; end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " dut1"}, int'({req1, wr1, pready1, pslverr1, prdata1, addr1, wdata1}), 0);
        chk({tag, " dut3"}, int'({req3, wr3, pready3, pslverr3, prdata3, addr3, wdata3}), 0);
    endtask

    // Runs one APB transfer starting at the current negedge. Cycle 1 is the
    // cycle after the setup-phase edge. Returns at the negedge of the cycle
    // after the slower RESP (plus hold), so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int hold, input int exp_req, input int exp_c1,
                        input int exp_c3, input int exp_err, input logic [7:0] exp_rd,
                        input string tag);
        int n, c1, c3, pc1, pc3, r1s, r3s, last;
        logic e1, e3;
        logic [7:0] d1, d3;
        c1 = 0; c3 = 0; pc1 = 0; pc3 = 0; e1 = 1'b0; e3 = 1'b0; d1 = 8'h00; d3 = 8'h00;
        r1s = rq1; r3s = rq3;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (pready1) begin
                pc1++;
                if (c1 == 0) begin c1 = n; e1 = pslverr1; d1 = prdata1; end
            end
            if (pready3) begin
                pc3++;
                if (c3 == 0) begin c3 = n; e3 = pslverr3; d3 = prdata3; end
            end
            penable = 1'b1;
            last = (c1 > c3) ? c1 : c3;
            if (c1 != 0 && c3 != 0 && n >= last + 1 + hold) break;
        end
        psel = 1'b0; penable = 1'b0;
        chk({tag, " req1"}, rq1 - r1s, exp_req);
        chk({tag, " req3"}, rq3 - r3s, exp_req);
        chk({tag, " cyc1"}, c1, exp_c1);
        chk({tag, " cyc3"}, c3, exp_c3);
        chk({tag, " npready1"}, pc1, 1);
        chk({tag, " npready3"}, pc3, 1);
        chk({tag, " err1"}, int'(e1), exp_err);
        chk({tag, " err3"}, int'(e3), exp_err);
        chk({tag, " rd1"}, int'(d1), int'(exp_rd));
        chk({tag, " rd3"}, int'(d3), int'(exp_rd));
        if (exp_req != 0) begin
            chk({tag, " cmd1"}, int'({cw1, ca1, cd1}), int'({wr, a, d}));
            chk({tag, " cmd3"}, int'({cw3, ca3, cd3}), int'({wr, a, d}));
        end
    endtask

    initial begin
        int pr;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(1'b1, 8'h01, 8'hA5, 0, 1, 2, 2, 0, 8'h00, "wr01");
        xfer(1'b0, 8'h01, 8'h00, 0, 1, 3, 5, 0, 8'hA5, "rd01");
        xfer(1'b1, 8'h03, 8'h3C, 0, 1, 2, 2, 0, 8'h00, "wr03");
        xfer(1'b0, 8'h03, 8'h00, 0, 1, 3, 5, 0, 8'h3C, "rd03");
        xfer(1'b1, 8'h20, 8'h77, 0, 0, 1, 1, 1, 8'h00, "wr20_oor");
        xfer(1'b0, 8'h10, 8'h00, 0, 0, 1, 1, 1, 8'h00, "rd10_oor");
        xfer(1'b1, 8'h0F, 8'h99, 0, 1, 2, 2, 0, 8'h00, "wr0f");
        xfer(1'b0, 8'h0F, 8'h00, 0, 1, 3, 5, 0, 8'h99, "rd0f");
        xfer(1'b1, 8'h00, 8'h01, 3, 1, 2, 2, 0, 8'h00, "b2b_wr00");
        xfer(1'b0, 8'h02, 8'h00, 3, 1, 3, 5, 0, 8'h5A, "b2b_rd02");

        // Reset during WAIT of a read.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h01; pwdata = 8'h00;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        psel = 1'b0; penable = 1'b0;
        pr = 0;
        repeat (4) begin
            @(negedge clk);
            pr += int'(pready1) + int'(pready3);
        end
        chk("rst_mid pready", pr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 8'h01, 8'h00, 0, 1, 3, 5, 0, 8'hA5, "rd01_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
